sipo_deframer: RTL and testbench
================================

Name: sipo_deframer

Overview:
- Serial-in parallel-out receive stage that consumes the 1-bit stream produced by the team's 4-bit parallel-load shift register, MSB first.
- Aligns word boundaries on a sync strobe and reassembles WIDTH-bit words.
- Presents each word through a one-entry valid/ready output buffer.
- Flags overrun (consumer too slow) and framing errors (sync arriving mid-word).

Parameters:
- WIDTH, 4, bits per word; legal range is 2 to 16.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- sin  input  1  serial data bit, MSB of each word first.
- sin_valid  input  1  qualifies sin; a bit is consumed only on a cycle where sin_valid=1.
- sync  input  1  qualified by sin_valid; marks the current sin bit as the MSB of a new word.
- dout  output  WIDTH  assembled word.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout on a cycle where dout_valid=1 and dout_ready=1.
- locked  output  1  a word boundary has been established.
- overrun  output  1  sticky; a completed word was dropped.
- frame_err  output  1  sticky; sync arrived with a partial word in progress.
- clr_flags  input  1  synchronous clear of overrun and frame_err.

Behaviour:
- Reset (asserted low, asynchronous): shift reg=0, bit count=0, state=HUNT, dout=0, dout_valid=0, locked=0, overrun=0, frame_err=0.
- States are HUNT and LOCK; locked=1 exactly in LOCK.
- HUNT:
  - Bits without sync are discarded.
  - sin_valid&sync: shift reg={..,sin}, count=1, go to LOCK.
- LOCK, on each cycle with sin_valid:
  - Shift left by one: shreg={shreg[WIDTH-2:0],sin}, count+=1.
  - When count reaches WIDTH, the word is complete: word={shreg[WIDTH-2:0],sin}, count wraps to 0, state stays LOCK.
  - Framing is continuous: after lock, words run back-to-back with no further sync required.
- sync in LOCK:
  - count==0: normal word start, no error.
  - count!=0: set frame_err, discard the partial word, treat the sync bit as the MSB of a new word (count=1).
- sin_valid=0: no shift, no count change; sync is ignored.
- Output buffer (one entry):
  - Completed word, buffer empty or being accepted this cycle: dout<=word, dout_valid=1 on the next cycle.
  - Latency: the last bit sampled at edge N gives dout_valid=1 immediately after edge N.
  - Completed word while dout_valid=1 and dout_ready=0: word dropped, overrun<=1, dout unchanged.
  - Accept with no new word completing: dout_valid<=0; dout keeps its last value.
  - Simultaneous accept and completion: dout<=new word, dout_valid stays 1, no overrun.
  - dout and dout_valid change only at clock edges; dout is stable while dout_valid=1 and dout_ready=0.
- Flags:
  - overrun and frame_err stay set until clr_flags=1 or reset.
  - clr_flags and a set event on the same cycle: set wins (flag=1).
- Reset mid-word or mid-handshake: all state is cleared immediately, with no dout_valid glitch-high, and the block returns to HUNT.
- dout_ready while dout_valid=0: no effect.

Test Plan:
- Basic word, WIDTH=4:
  - Stimulus: sync with the first bit, then stream 1,0,1,1 with sin_valid=1 and dout_ready=1.
  - Required: dout=4'hB and dout_valid=1 for one cycle after the 4th bit; locked=1 from the first bit.
- Back-to-back words:
  - Stimulus: after lock, stream 8 bits (4'hA, then 4'h5) with no second sync.
  - Required: two valid pulses, 4 cycles apart, dout=A then 5.
- Gaps:
  - Stimulus: same 4'hB, with sin_valid=0 inserted between every bit.
  - Required: identical dout; count holds during gaps.
- Backpressure and overrun:
  - Stimulus: dout_ready=0; receive 4'h3, then 4'hC.
  - Required: dout stays 3, overrun=1.
  - Stimulus: raise dout_ready, then pulse clr_flags.
  - Required: dout_valid drops; overrun returns to 0.
- Resync:
  - Stimulus: after 2 bits of a word, assert sync with bits 0,1,1,0.
  - Required: frame_err=1, partial word discarded, dout=4'h6.
- Reset mid-word:
  - Stimulus: assert reset low between clock edges after 3 bits of a word.
  - Required: outputs cleared immediately, locked=0; bits after release are ignored until the next sync.

Source files
------------

// File: rtl/sipo_deframer.sv
// Serial-in parallel-out deframer: aligns on a sync strobe, reassembles
// WIDTH-bit words (MSB first) and hands them out through a one-entry
// valid/ready buffer. Sticky flags report dropped words and mid-word syncs.
module sipo_deframer #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sin,
   input  logic             sin_valid,
   input  logic             sync,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             locked,
   output logic             overrun,
   output logic             frame_err,
   input  logic             clr_flags
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   typedef enum logic {StHunt, StLock} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             dout_valid_q, dout_valid_d;
   logic             overrun_q, overrun_d;
   logic             frame_err_q, frame_err_d;

   logic [WIDTH-1:0] shifted;
   logic             word_done;
   logic             fe_set;
   logic             ov_set;

   assign shifted = {shreg_q[WIDTH-2:0], sin};

   // Alignment FSM: hunt for sync, then count bits into back-to-back words.
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      cnt_d     = cnt_q;
      word_done = 1'b0;
      fe_set    = 1'b0;
      unique case (state_q)
         StHunt: begin
            if (sin_valid && sync) begin
               shreg_d = shifted;
               cnt_d   = CntW'(1);
               state_d = StLock;
            end
         end
         StLock: begin
            if (sin_valid) begin
               shreg_d = shifted;
               if (sync && (cnt_q != '0)) begin
                  // Partial word is abandoned; this bit becomes the new MSB.
                  fe_set = 1'b1;
                  cnt_d  = CntW'(1);
               end else if (cnt_q == LastCnt) begin
                  word_done = 1'b1;
                  cnt_d     = '0;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
         end
         default: state_d = StHunt;
      endcase
   end

   // Output buffer and sticky flags; a set event beats a same-cycle clear.
   always_comb begin
      dout_d       = dout_q;
      dout_valid_d = dout_valid_q;
      ov_set       = 1'b0;
      if (word_done) begin
         if (!dout_valid_q || dout_ready) begin
            dout_d       = shifted;
            dout_valid_d = 1'b1;
         end else begin
            ov_set = 1'b1;
         end
      end else if (dout_valid_q && dout_ready) begin
         dout_valid_d = 1'b0;
      end
      overrun_d   = (overrun_q & ~clr_flags) | ov_set;
      frame_err_d = (frame_err_q & ~clr_flags) | fe_set;
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= StHunt;
         shreg_q      <= '0;
         cnt_q        <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         shreg_q      <= shreg_d;
         cnt_q        <= cnt_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         overrun_q    <= overrun_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign locked     = (state_q == StLock);
   assign overrun    = overrun_q;
   assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_sipo_deframer.sv
// Bench for sipo_deframer: directed scenarios followed by random traffic,
// every cycle checked against a bit-queue reference model.
module tb_sipo_deframer;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         sin;
   logic         sin_valid;
   logic         sync;
   logic [W-1:0] dout;
   logic         dout_valid;
   logic         dout_ready;
   logic         locked;
   logic         overrun;
   logic         frame_err;
   logic         clr_flags;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model state: bits of the word in progress, plus buffer/flags.
   bit           m_lock;
   bit           m_bits[$];
   logic [W-1:0] m_dout;
   bit           m_valid;
   bit           m_ov;
   bit           m_fe;

   sipo_deframer #(.WIDTH(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .sin        (sin),
      .sin_valid  (sin_valid),
      .sync       (sync),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .locked     (locked),
      .overrun    (overrun),
      .frame_err  (frame_err),
      .clr_flags  (clr_flags)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_lock  = 1'b0;
      m_bits.delete();
      m_dout  = '0;
      m_valid = 1'b0;
      m_ov    = 1'b0;
      m_fe    = 1'b0;
   endtask

   task automatic model_step(bit v, bit s, bit sy, bit rdy, bit clr);
      bit           done = 1'b0;
      bit           fe_set = 1'b0;
      bit           ov_set = 1'b0;
      logic [W-1:0] w = '0;
      if (v) begin
         if (!m_lock) begin
            if (sy) begin
               m_lock = 1'b1;
               m_bits.delete();
               m_bits.push_back(s);
            end
         end else begin
            if (sy && m_bits.size() != 0) begin
               fe_set = 1'b1;
               m_bits.delete();
            end
            m_bits.push_back(s);
            if (m_bits.size() == W) begin
               done = 1'b1;
               foreach (m_bits[i]) w = W'(w * 2 + int'(m_bits[i]));
               m_bits.delete();
            end
         end
      end
      if (done) begin
         if (!m_valid || rdy) begin
            m_dout  = w;
            m_valid = 1'b1;
         end else begin
            ov_set = 1'b1;
         end
      end else if (m_valid && rdy) begin
         m_valid = 1'b0;
      end
      if (clr) begin
         m_ov = 1'b0;
         m_fe = 1'b0;
      end
      if (ov_set) m_ov = 1'b1;
      if (fe_set) m_fe = 1'b1;
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("dout", 32'(dout), 32'(m_dout));
      chk("dout_valid", 32'(dout_valid), 32'(m_valid));
      chk("locked", 32'(locked), 32'(m_lock));
      chk("overrun", 32'(overrun), 32'(m_ov));
      chk("frame_err", 32'(frame_err), 32'(m_fe));
   endtask

   // One clock: drive inputs, update the model at the edge, sample 1 unit later.
   task automatic cyc(bit v, bit s, bit sy, bit rdy, bit clr);
      sin_valid  = v;
      sin        = s;
      sync       = sy;
      dout_ready = rdy;
      clr_flags  = clr;
      @(posedge clk);
      model_step(v, s, sy, rdy, clr);
      #1;
      check_all();
   endtask

   task automatic send_word(logic [W-1:0] value, bit first_sync, bit rdy);
      for (int i = W - 1; i >= 0; i--) begin
         cyc(1'b1, value[i], first_sync && (i == W - 1), rdy, 1'b0);
      end
   endtask

   initial begin
      logic [W-1:0] gap_word;
      reset      = 1'b0;
      sin        = 1'b0;
      sin_valid  = 1'b0;
      sync       = 1'b0;
      dout_ready = 1'b0;
      clr_flags  = 1'b0;
      model_reset();
      #12;
      check_all();
      chk("reset_locked", 32'(locked), 32'd0);
      reset = 1'b1;

      // Basic word 4'hB
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("basic_locked_first_bit", 32'(locked), 32'd1);
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("basic_dout", 32'(dout), 32'hB);
      chk("basic_valid", 32'(dout_valid), 32'd1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("basic_valid_drop", 32'(dout_valid), 32'd0);

      // Back-to-back words without a second sync
      send_word(4'hA, 1'b0, 1'b1);
      chk("b2b_first", 32'(dout), 32'hA);
      send_word(4'h5, 1'b0, 1'b1);
      chk("b2b_second", 32'(dout), 32'h5);
      chk("b2b_second_valid", 32'(dout_valid), 32'd1);

      // Gaps between every bit; sync during gaps must be ignored
      gap_word = 4'hB;
      for (int i = W - 1; i >= 0; i--) begin
         cyc(1'b1, gap_word[i], i == W - 1, 1'b1, 1'b0);
         if (i == 0) chk("gap_dout", 32'(dout), 32'hB);
         cyc(1'b0, 1'($urandom), 1'($urandom), 1'b1, 1'b0);
      end
      chk("gap_no_frame_err", 32'(frame_err), 32'd0);

      // Backpressure and overrun
      send_word(4'h3, 1'b0, 1'b0);
      send_word(4'hC, 1'b0, 1'b0);
      chk("bp_dout_held", 32'(dout), 32'h3);
      chk("bp_overrun", 32'(overrun), 32'd1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("bp_valid_drop", 32'(dout_valid), 32'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("bp_overrun_clr", 32'(overrun), 32'd0);

      // Resync after two bits
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      send_word(4'h6, 1'b1, 1'b1);
      chk("resync_frame_err", 32'(frame_err), 32'd1);
      chk("resync_dout", 32'(dout), 32'h6);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

      // Mid-word sync together with clr_flags: set wins
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      chk("set_beats_clr", 32'(frame_err), 32'd1);
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("set_beats_clr_dout", 32'(dout), 32'h7);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

      // Reset mid-word while a word is pending and flags are set
      send_word(4'h9, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      check_all();
      chk("rst_valid_now", 32'(dout_valid), 32'd0);
      chk("rst_locked_now", 32'(locked), 32'd0);
      #3;
      reset = 1'b1;
      send_word(4'hF, 1'b0, 1'b1);
      chk("rst_hunt_locked", 32'(locked), 32'd0);
      chk("rst_hunt_valid", 32'(dout_valid), 32'd0);
      send_word(4'hD, 1'b1, 1'b1);
      chk("rst_relock_dout", 32'(dout), 32'hD);

      // Random traffic against the model
      for (int n = 0; n < 3000; n++) begin
         cyc($urandom_range(3, 0) != 0, 1'($urandom), $urandom_range(9, 0) == 0,
             $urandom_range(9, 0) < 7, $urandom_range(19, 0) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
